adder_tree_pipelined: RTL

//  Sums N_INPUTS packed operands in a fully registered binary adder tree, with bit growth and no overflow.

---
 rtl/adder_tree_pipelined_pkg.sv | 29 ++
 rtl/adder_tree_level.sv | 32 +++
 rtl/adder_tree_pipelined.sv | 81 ++++++++
 3 files changed

// File: rtl/adder_tree_pipelined_pkg.sv
// rtl/adder_tree_pipelined_pkg.sv - shared constants and elaboration helpers for the adder tree
package adder_tree_pipelined_pkg;

  localparam string STR_TRUE  = "TRUE";
  localparam string STR_FALSE = "FALSE";

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Start bit of level lvl's operand vector inside the flattened tree bus.
  function automatic int level_offset(input int n_pad, input int in_w, input int lvl);
    int off;
    off = 0;
    for (int j = 0; j < lvl; j++) begin
      off = off + (n_pad >> j) * (in_w + j);
    end
    return off;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// rtl/adder_tree_level.sv - one registered level of the tree: N_PAIRS adjacent sums, W_IN -> W_IN+1
module adder_tree_level
  import adder_tree_pipelined_pkg::*;
#(
  parameter int    N_PAIRS   = 4,
  parameter int    W_IN      = 8,
  parameter string IS_SIGNED = "TRUE"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [2*N_PAIRS*W_IN-1:0]  din,
  output logic [N_PAIRS*(W_IN+1)-1:0] dout
);

  localparam bit SIGNED_OPS = (IS_SIGNED == STR_TRUE);

  function automatic logic [W_IN:0] ext(input logic [W_IN-1:0] v);
    return SIGNED_OPS ? {v[W_IN-1], v} : {1'b0, v};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (ce) begin
      for (int p = 0; p < N_PAIRS; p++) begin
        dout[p*(W_IN+1) +: W_IN+1] <= ext(din[2*p*W_IN +: W_IN]) + ext(din[(2*p+1)*W_IN +: W_IN]);
      end
    end
  end

endmodule

// File: rtl/adder_tree_pipelined.sv
// rtl/adder_tree_pipelined.sv - fully registered binary adder tree with bit growth, ce and valid tracking
module adder_tree_pipelined
  import adder_tree_pipelined_pkg::*;
#(
  parameter int    N_INPUTS       = 8,
  parameter int    IN_WIDTH       = 8,
  parameter string IS_SIGNED      = "TRUE",
  parameter string REGISTER_INPUT = "FALSE"
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ce,
  input  logic [N_INPUTS*IN_WIDTH-1:0]          din,
  input  logic                                  din_vld,
  output logic [IN_WIDTH+clog2(N_INPUTS)-1:0]   dout,
  output logic                                  dout_vld
);

  localparam int LEVELS    = clog2(N_INPUTS);
  localparam int OUT_WIDTH = IN_WIDTH + LEVELS;
  localparam bit REG_IN    = (REGISTER_INPUT == STR_TRUE);
  localparam int LATENCY   = LEVELS + (REG_IN ? 1 : 0);
  localparam int N_PAD     = 1 << LEVELS;
  localparam int OUT_OFF   = level_offset(N_PAD, IN_WIDTH, LEVELS);

  logic [N_INPUTS*IN_WIDTH-1:0]  din_s;
  logic [N_PAD*IN_WIDTH-1:0]     padded;
  logic [OUT_OFF+OUT_WIDTH-1:0]  tree;
  logic [LATENCY-1:0]            vld_sr;

  if (REG_IN) begin : g_in_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        din_s <= '0;
      end else if (ce) begin
        din_s <= din;
      end
    end
  end else begin : g_in_wire
    assign din_s = din;
  end

  // Missing operands up to the next power of two are constant zero.
  always_comb begin
    padded = '0;
    padded[N_INPUTS*IN_WIDTH-1:0] = din_s;
  end

  assign tree[N_PAD*IN_WIDTH-1:0] = padded;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int W       = IN_WIDTH + l;
    localparam int P       = N_PAD >> (l + 1);
    localparam int OFF_IN  = level_offset(N_PAD, IN_WIDTH, l);
    localparam int OFF_OUT = level_offset(N_PAD, IN_WIDTH, l + 1);

    adder_tree_level #(
      .N_PAIRS   (P),
      .W_IN      (W),
      .IS_SIGNED (IS_SIGNED)
    ) u_level (
      .clk  (clk),
      .rst  (rst),
      .ce   (ce),
      .din  (tree[OFF_IN +: 2*P*W]),
      .dout (tree[OFF_OUT +: P*(W+1)])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else if (ce) begin
      vld_sr <= (vld_sr << 1) | LATENCY'(din_vld);
    end
  end

  assign dout     = tree[OUT_OFF +: OUT_WIDTH];
  assign dout_vld = vld_sr[LATENCY-1];

endmodule
